// File: rtl/hdlc_tx_sequencer.sv
// hdlc_tx_sequencer: HDLC transmit framing with flags, zero insertion, CRC-16 FCS and abort
module hdlc_tx_sequencer #(
   parameter int MAX_FRAME = 126,
   parameter bit FCS_EN    = 1'b1
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Tx_Enable,
   input  logic       Tx_AbortFrame,
   input  logic       Tx_DataAvail,
   input  logic [7:0] Tx_FrameSize,
   input  logic [7:0] Tx_DataOutBuff,
   output logic       Tx_RdBuff,
   output logic       Tx,
   output logic       Tx_ValidFrame,
   output logic       Tx_Done,
   output logic       Tx_AbortedTrans
);
   localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, FCS = 3'd3, ENDFLAG = 3'd4, ABORT = 3'd5;
   logic [2:0]  state;
   logic [3:0]  bitIdx;
   logic        stuffing;
   logic [2:0]  onesCnt;
   logic [7:0]  shiftReg;
   logic [7:0]  holdByte;
   logic        rdDly;
   logic        havNext;
   logic [7:0]  bytesLeft;
   logic [15:0] crc;
   logic [15:0] crcNext;
   logic [7:0]  nextByte;
   logic        nextBit;
   logic        canStart;
   logic        abortNow;
   logic        stuffNow;
   logic        fb;
   // Bit-serial reflected CRC step, next-bit selection and status decode
   always_comb begin
      fb            = crc[0] ^ Tx;
      crcNext       = {1'b0, crc[15:1]} ^ ({16{fb}} & 16'hA001);
      nextByte      = rdDly ? Tx_DataOutBuff : holdByte;
      nextBit       = state == FCS ? crc[bitIdx + 4'd1] :
                      bitIdx != 4'd7 ? shiftReg[bitIdx[2:0] + 3'd1] :
                      havNext ? nextByte[0] : stuffing ? crc[0] : crcNext[0];
      canStart      = Tx_Enable && Tx_DataAvail && Tx_FrameSize != 8'd0 && {24'd0, Tx_FrameSize} <= MAX_FRAME;
      abortNow      = Tx_AbortFrame && (state == START || state == DATA || state == FCS);
      stuffNow      = (state == DATA || state == FCS) && onesCnt == 3'd5;
      Tx_RdBuff     = bytesLeft != 8'd0 && bitIdx == 4'd6 && (state == START || (state == DATA && !stuffing));
      Tx_Done       = Tx_RdBuff && bytesLeft == 8'd1;
      Tx_ValidFrame = state != IDLE && state != ABORT;
      Tx_AbortedTrans = state == ABORT && bitIdx == 4'd0;
   end
   // Each cycle places the next line bit on Tx; state and bitIdx always describe the bit on the line
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         bitIdx    <= 4'd0;
         Tx        <= 1'b1;
         stuffing  <= 1'b0;
         onesCnt   <= 3'd0;
         shiftReg  <= 8'd0;
         holdByte  <= 8'd0;
         rdDly     <= 1'b0;
         havNext   <= 1'b0;
         bytesLeft <= 8'd0;
         crc       <= 16'd0;
      end else begin
         rdDly    <= Tx_RdBuff;
         stuffing <= 1'b0;
         if (rdDly) holdByte <= Tx_DataOutBuff;
         if (Tx_RdBuff) begin
            bytesLeft <= bytesLeft - 8'd1;
            havNext   <= 1'b1;
         end
         if (state == DATA && !stuffing) crc <= crcNext;
         if (abortNow) begin
            state  <= ABORT;
            bitIdx <= 4'd0;
            Tx     <= 1'b0;
         end else if (stuffNow) begin
            stuffing <= 1'b1;
            Tx       <= 1'b0;
            onesCnt  <= 3'd0;
         end else begin
            case (state)
               IDLE: if (canStart) begin
                  state     <= START;
                  bitIdx    <= 4'd0;
                  Tx        <= 1'b0;
                  bytesLeft <= Tx_FrameSize;
                  crc       <= 16'd0;
                  havNext   <= 1'b0;
                  onesCnt   <= 3'd0;
               end
               START: if (bitIdx == 4'd7) begin
                  state    <= DATA;
                  bitIdx   <= 4'd0;
                  shiftReg <= nextByte;
                  havNext  <= 1'b0;
                  Tx       <= nextByte[0];
                  onesCnt  <= {2'b00, nextByte[0]};
               end else begin
                  bitIdx <= bitIdx + 4'd1;
                  Tx     <= bitIdx != 4'd6;
               end
               DATA: if (bitIdx != 4'd7 || havNext) begin
                  bitIdx  <= {1'b0, bitIdx[2:0] + 3'd1};
                  Tx      <= nextBit;
                  onesCnt <= nextBit ? onesCnt + 3'd1 : 3'd0;
                  if (bitIdx == 4'd7) begin
                     shiftReg <= nextByte;
                     havNext  <= 1'b0;
                  end
               end else if (FCS_EN) begin
                  state   <= FCS;
                  bitIdx  <= 4'd0;
                  Tx      <= nextBit;
                  onesCnt <= nextBit ? onesCnt + 3'd1 : 3'd0;
               end else begin
                  state   <= ENDFLAG;
                  bitIdx  <= 4'd0;
                  Tx      <= 1'b0;
                  onesCnt <= 3'd0;
               end
               FCS: if (bitIdx != 4'd15) begin
                  bitIdx  <= bitIdx + 4'd1;
                  Tx      <= nextBit;
                  onesCnt <= nextBit ? onesCnt + 3'd1 : 3'd0;
               end else begin
                  state   <= ENDFLAG;
                  bitIdx  <= 4'd0;
                  Tx      <= 1'b0;
                  onesCnt <= 3'd0;
               end
               ENDFLAG: if (bitIdx == 4'd7) begin
                  state <= IDLE;
                  Tx    <= 1'b1;
               end else begin
                  bitIdx <= bitIdx + 4'd1;
                  Tx     <= bitIdx != 4'd6;
               end
               ABORT: begin
                  Tx <= 1'b1;
                  if (bitIdx == 4'd7) state <= IDLE;
                  else bitIdx <= bitIdx + 4'd1;
               end
               default: begin
                  state <= IDLE;
                  Tx    <= 1'b1;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// tb_hdlc_tx_sequencer: checks two sequencer instances (without and with FCS) against a line-level frame model
module tb_hdlc_tx_sequencer;
   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       Tx_Enable = 1'b0;
   logic       Tx_AbortFrame = 1'b0;
   logic       Tx_DataAvail = 1'b0;
   logic [7:0] Tx_FrameSize = 8'd0;
   logic [7:0] buf0, buf1;
   logic       rd0, rd1, tx0, tx1, vf0, vf1, dn0, dn1, ab0, ab1;
   logic [7:0] frm [0:127];
   logic [6:0] p0, p1;
   logic       bufRst = 1'b1;
   int         checks = 0;
   int         failures = 0;
   bit         mq[$];
   bit         exp0[$];
   bit         exp1[$];
   bit         got0[$];
   bit         got1[$];
   int         mOnes;
   int         abPos;
   int         lastVf0, lastVf1;

   always #5 Clk = ~Clk;

   hdlc_tx_sequencer #(.MAX_FRAME(126), .FCS_EN(1'b0)) d0 (
      .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame),
      .Tx_DataAvail(Tx_DataAvail), .Tx_FrameSize(Tx_FrameSize), .Tx_DataOutBuff(buf0),
      .Tx_RdBuff(rd0), .Tx(tx0), .Tx_ValidFrame(vf0), .Tx_Done(dn0), .Tx_AbortedTrans(ab0));

   hdlc_tx_sequencer #(.MAX_FRAME(126), .FCS_EN(1'b1)) d1 (
      .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame),
      .Tx_DataAvail(Tx_DataAvail), .Tx_FrameSize(Tx_FrameSize), .Tx_DataOutBuff(buf1),
      .Tx_RdBuff(rd1), .Tx(tx1), .Tx_ValidFrame(vf1), .Tx_Done(dn1), .Tx_AbortedTrans(ab1));

   // Tx buffer model: each read pulse pops the next frame byte, valid the following cycle
   always @(posedge Clk) begin
      if (bufRst) begin
         p0 <= 7'd0;
         p1 <= 7'd0;
      end else begin
         if (rd0) begin
            buf0 <= frm[p0];
            p0   <= p0 + 7'd1;
         end
         if (rd1) begin
            buf1 <= frm[p1];
            p1   <= p1 + 7'd1;
         end
      end
   end

   task automatic chk(input string tag, input int got, input int want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'd0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      return r;
   endfunction

   task automatic putStuffed(input bit b);
      mq.push_back(b);
      mOnes = b ? mOnes + 1 : 0;
      if (mOnes == 5) begin
         mq.push_back(1'b0);
         mOnes = 0;
      end
   endtask

   task automatic putFlag();
      for (int i = 0; i < 8; i++) mq.push_back(i != 0 && i != 7);
   endtask

   task automatic buildLine(input int n, input bit fcs);
      logic [15:0] c;
      mq = {};
      mOnes = 0;
      c = 16'd0;
      abPos = -1;
      putFlag();
      for (int k = 0; k < n; k++) begin
         c = crcByte(c, frm[k[6:0]]);
         for (int i = 0; i < 8; i++) begin
            if (k == 1 && i == 2) abPos = mq.size();
            putStuffed(frm[k[6:0]][i]);
         end
      end
      if (fcs) for (int i = 0; i < 16; i++) putStuffed(c[i]);
      putFlag();
   endtask

   task automatic runFrame(input string tag, input int n, input bit abortAtStart, input bit abortMid, input bit enNoise);
      int pos, total, bad0, bad1, nrd0, nrd1, ndn0, ndn1, nab0, nab1, nvf0, nvf1, dnAt0, dnAt1, abAt0, abAt1;
      bit w0, w1;
      buildLine(n, 1'b0);
      exp0 = mq;
      pos = abPos;
      buildLine(n, 1'b1);
      exp1 = mq;
      if (abortMid) begin
         while (exp0.size() > pos + 1) void'(exp0.pop_back());
         while (exp1.size() > pos + 1) void'(exp1.pop_back());
         for (int i = 0; i < 8; i++) begin
            exp0.push_back(i != 0);
            exp1.push_back(i != 0);
         end
      end
      total = (exp0.size() > exp1.size() ? exp0.size() : exp1.size()) + 4;
      {bad0, bad1, dnAt0, dnAt1, abAt0, abAt1} = {6{-32'sd1}};
      {nrd0, nrd1, ndn0, ndn1, nab0, nab1, nvf0, nvf1} = '0;
      got0 = {};
      got1 = {};
      @(negedge Clk);
      bufRst = 1'b1;
      @(negedge Clk);
      bufRst = 1'b0;
      Tx_FrameSize = 8'(n);
      Tx_DataAvail = 1'b1;
      Tx_Enable = 1'b1;
      Tx_AbortFrame = abortAtStart;
      for (int s = 0; s < total; s++) begin
         @(negedge Clk);
         Tx_Enable = enNoise && s == 3;
         Tx_AbortFrame = abortMid && s == pos;
         got0.push_back(tx0);
         got1.push_back(tx1);
         w0 = s < exp0.size() ? exp0[s] : 1'b1;
         w1 = s < exp1.size() ? exp1[s] : 1'b1;
         if (tx0 !== w0 && bad0 < 0) bad0 = s;
         if (tx1 !== w1 && bad1 < 0) bad1 = s;
         if (rd0) nrd0++;
         if (rd1) nrd1++;
         if (dn0) begin ndn0++; dnAt0 = rd0 ? nrd0 : -2; end
         if (dn1) begin ndn1++; dnAt1 = rd1 ? nrd1 : -2; end
         if (ab0) begin nab0++; abAt0 = s; end
         if (ab1) begin nab1++; abAt1 = s; end
         if (vf0) nvf0++;
         if (vf1) nvf1++;
      end
      Tx_DataAvail = 1'b0;
      lastVf0 = nvf0;
      lastVf1 = nvf1;
      chk({tag, "/line0_firstbad"}, bad0, -1);
      chk({tag, "/line1_firstbad"}, bad1, -1);
      chk({tag, "/valid0"}, nvf0, abortMid ? pos + 1 : exp0.size());
      chk({tag, "/valid1"}, nvf1, abortMid ? pos + 1 : exp1.size());
      chk({tag, "/rd0"}, nrd0, abortMid ? 2 : n);
      chk({tag, "/rd1"}, nrd1, abortMid ? 2 : n);
      chk({tag, "/done0"}, ndn0, abortMid ? 0 : 1);
      chk({tag, "/done1"}, ndn1, abortMid ? 0 : 1);
      chk({tag, "/abort0"}, nab0, abortMid ? 1 : 0);
      chk({tag, "/abort1"}, nab1, abortMid ? 1 : 0);
      if (abortMid) begin
         chk({tag, "/abort_at0"}, abAt0, pos + 1);
         chk({tag, "/abort_at1"}, abAt1, pos + 1);
      end else begin
         chk({tag, "/done_at0"}, dnAt0, n);
         chk({tag, "/done_at1"}, dnAt1, n);
      end
   endtask

   task automatic noStart(input string tag, input int sz, input bit av);
      int bad;
      bad = 0;
      @(negedge Clk);
      Tx_FrameSize = 8'(sz);
      Tx_DataAvail = av;
      Tx_Enable = 1'b1;
      for (int s = 0; s < 12; s++) begin
         @(negedge Clk);
         Tx_Enable = 1'b0;
         if (tx0 !== 1'b1 || tx1 !== 1'b1 || vf0 !== 1'b0 || vf1 !== 1'b0 || rd0 !== 1'b0 || rd1 !== 1'b0) bad++;
      end
      Tx_DataAvail = 1'b0;
      chk(tag, bad, 0);
   endtask

   initial begin
      logic [31:0] v;
      int bad;
      repeat (3) @(negedge Clk);
      chk("reset0", int'({tx0, vf0, rd0, dn0, ab0}), 16);
      chk("reset1", int'({tx1, vf1, rd1, dn1, ab1}), 16);
      Rst = 1'b0;
      bufRst = 1'b0;
      bad = 0;
      for (int s = 0; s < 20; s++) begin
         @(negedge Clk);
         if (tx0 !== 1'b1 || tx1 !== 1'b1 || rd0 || rd1 || dn0 || dn1 || ab0 || ab1) bad++;
      end
      chk("idle20", bad, 0);

      frm[0] = 8'h01;
      frm[1] = 8'h80;
      runFrame("two", 2, 1'b0, 1'b0, 1'b0);
      v = '0;
      for (int i = 0; i < 32; i++) v = {v[30:0], got0[i]};
      chk("two_pattern", int'(v), int'(32'b01111110100000000000000101111110));
      chk("two_valid_len", lastVf0, 32);

      frm[0] = 8'hFF;
      runFrame("ff", 1, 1'b0, 1'b0, 1'b0);
      v = '0;
      for (int i = 8; i < 17; i++) v = {v[30:0], got0[i]};
      chk("ff_data", int'(v), int'(9'b111110111));
      chk("ff_valid_len", lastVf0, 25);

      frm[0] = 8'h00;
      runFrame("zero", 1, 1'b0, 1'b0, 1'b0);
      v = '0;
      for (int i = 16; i < 32; i++) v = {v[30:0], got1[i]};
      chk("zero_fcs", int'(v), 0);
      v = '0;
      for (int i = 32; i < 40; i++) v = {v[30:0], got1[i]};
      chk("zero_endflag", int'(v), int'(8'b01111110));

      for (int i = 0; i < 5; i++) frm[i] = 8'($urandom);
      runFrame("abort", 5, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 3; i++) frm[i] = 8'($urandom);
      runFrame("en_with_abort", 3, 1'b1, 1'b0, 1'b0);

      noStart("nostart_size0", 0, 1'b1);
      noStart("nostart_size127", 127, 1'b1);
      noStart("nostart_noavail", 4, 1'b0);

      @(negedge Clk);
      bufRst = 1'b1;
      @(negedge Clk);
      bufRst = 1'b0;
      Tx_FrameSize = 8'd3;
      Tx_DataAvail = 1'b1;
      Tx_Enable = 1'b1;
      repeat (12) begin
         @(negedge Clk);
         Tx_Enable = 1'b0;
      end
      Rst = 1'b1;
      Tx_DataAvail = 1'b0;
      @(negedge Clk);
      chk("midrst0", int'({tx0, vf0, ab0}), 4);
      chk("midrst1", int'({tx1, vf1, ab1}), 4);
      Rst = 1'b0;

      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) frm[i] = 8'($urandom);
         runFrame("rand", n, 1'b0, 1'b0, r[0]);
      end

      for (int i = 0; i < 126; i++) frm[i] = 8'($urandom);
      runFrame("max126", 126, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hdlc_tx_sequencer.md
Name: hdlc_tx_sequencer

Overview:
Transmit-side frame controller for the HDLC core. It is started by a command strobe and fetches bytes from the Tx buffer through a read handshake. It sequences the serial Tx line through idle, start flag, data, FCS, end flag and abort phases, inserting a zero after every five consecutive 1s. It generates the Tx_ValidFrame, Tx_Done and Tx_AbortedTrans status, which the Tx assertion set checks.

Parameters:
MAX_FRAME, 126, largest accepted frame size in bytes, excluding the FCS.
FCS_EN, 1, 1 = append a 16-bit FCS; 0 = go directly from the data phase to the end flag.

Ports:
Clk  in  1  system clock; one serial bit per cycle.
Rst  in  1  synchronous reset, active-high.
Tx_Enable  in  1  start strobe; sampled only in IDLE.
Tx_AbortFrame  in  1  abort request.
Tx_DataAvail  in  1  Tx buffer holds a frame.
Tx_FrameSize  in  8  number of data bytes in the frame.
Tx_DataOutBuff  in  8  byte from the Tx buffer; valid the cycle after Tx_RdBuff.
Tx_RdBuff  out  1  one-cycle pulse that pops one buffer byte.
Tx  out  1  registered serial line.
Tx_ValidFrame  out  1  high while a frame is being transmitted.
Tx_Done  out  1  one-cycle pulse when the last data byte has been fetched.
Tx_AbortedTrans  out  1  one-cycle pulse when an abort begins.

Behaviour:
Reset values:
- Tx=1; all other outputs 0.
- State IDLE; all counters, shift register and CRC cleared.
- Reset mid-frame: Tx=1 on the next cycle; no abort pattern is sent; no status pulses.

Bit conventions:
- Bytes are sent LSB first.
- Flag 0x7E appears on the line as 0,1,1,1,1,1,1,0.
- Abort 0x7F appears on the line as 0 then seven 1s.
- Idle line is constant 1.

IDLE:
- Tx=1.
- Go to START when Tx_Enable=1, Tx_DataAvail=1 and 1<=Tx_FrameSize<=MAX_FRAME. Otherwise the start strobe is ignored.
- Tx_FrameSize is latched on the start cycle.
- The first flag bit appears on Tx the cycle after Tx_Enable is sampled.

START:
- 8 flag bits, no stuffing.
- Tx_ValidFrame rises with the first flag bit.
- Tx_RdBuff pulses while flag bit index 6 is on the line.

DATA:
- The byte is loaded into the shift register on the cycle after Tx_RdBuff.
- The next byte's Tx_RdBuff pulses while data bit index 6 of the current byte is on the line, as long as bytes remain.
- If a stuffed zero delays the line, the pulse stays tied to bit 6; the loaded byte is held until the current byte finishes.
- Exactly Tx_FrameSize pulses are issued per frame.
- Tx_Done pulses on the cycle of the final Tx_RdBuff.
- After the last data bit: go to FCS if FCS_EN=1, otherwise to END.

Zero insertion:
- Applies in DATA and FCS only.
- A ones counter tracks consecutive 1s across byte boundaries and from DATA into FCS.
- After the fifth 1, the next line bit is a forced 0, the bit pointer stalls one cycle, and the counter clears.
- The counter clears on every transmitted 0 and on entering START or END.

FCS:
- CRC-16, polynomial x^16+x^15+x^2+1, initial value 0x0000, no final complement.
- Computed over the unstuffed data bits in transmit order.
- Sent as 16 bits, LSB first, with stuffing applied.

END:
- 8 flag bits, no stuffing.
- Tx_ValidFrame falls after the last flag bit, then return to IDLE.

Abort:
- Tx_AbortFrame=1 in START, DATA or FCS: the current bit completes, then go to ABORT.
- On entry to ABORT: Tx_AbortedTrans pulses and Tx_ValidFrame falls on the same cycle.
- ABORT sends 8 abort bits, then returns to IDLE.
- No further Tx_RdBuff and no Tx_Done after the abort request.
- Tx_AbortFrame is ignored in IDLE, END and ABORT.
- Tx_Enable together with Tx_AbortFrame in IDLE: the frame starts and the abort is ignored.
- Tx_Enable outside IDLE is ignored.

Test Plan:
- Reset, then idle for 20 cycles -> Tx=1 throughout; no Tx_RdBuff, Tx_Done or Tx_AbortedTrans pulses.
- FrameSize=2, bytes 0x01,0x80, FCS_EN=0 -> line carries 01111110 10000000 00000001 01111110; exactly 2 Tx_RdBuff pulses; Tx_Done on the 2nd pulse; Tx_ValidFrame high for 32 cycles.
- Byte 0xFF, FCS_EN=0 -> line data phase is 11111 0 111; data phase lasts 9 cycles; frame length 25 cycles.
- FrameSize=1, byte 0x00, FCS_EN=1 -> 16 FCS bits equal to CRC-16(0x00) = 0x0000 sent LSB first; end flag follows immediately.
- Tx_AbortFrame during the 3rd data bit of byte 2 of 5 -> bit finishes, then 0 followed by seven 1s; Tx_AbortedTrans single pulse; Tx_ValidFrame low from ABORT entry; total Tx_RdBuff pulses = 2; no Tx_Done.
- Tx_Enable with FrameSize=0, and with FrameSize=127, and with DataAvail=0 -> no start; Tx stays 1. Rst asserted mid-DATA -> Tx=1 and Tx_ValidFrame=0 the next cycle.
